// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, legal prescale values,
// parity-type encodings and a majority-vote helper.
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } rx_state_t;

  // Legal clocks-per-bit settings
  localparam int unsigned PRESCALE_8  = 8;
  localparam int unsigned PRESCALE_16 = 16;
  localparam int unsigned PRESCALE_32 = 32;

  // Parity type encodings, shared with the transmitter
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // 2-of-3 majority
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit edge counter and three-point majority sampler for the UART receiver.
// Samples the line at edges P/2-1, P/2 and P/2+1; the voted bit is presented
// (registered) during edge P/2+2. 'vote' is the same majority available
// combinationally during edge P/2+1 so the caller can register results early.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int unsigned PRESCALE_W = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_in,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  cnt_en,
  output logic [PRESCALE_W-1:0] edge_cnt,
  output logic                  bit_done,
  output logic                  sample_vld,
  output logic                  sampled_bit,
  output logic                  vote
);

  logic [PRESCALE_W-1:0] r_edge;
  logic                  r_s0;
  logic                  r_s1;
  logic                  r_vld;
  logic                  r_bit;

  logic [PRESCALE_W-1:0] w_last;
  logic [PRESCALE_W-1:0] w_half;
  logic [PRESCALE_W-1:0] w_half_m1;
  logic [PRESCALE_W-1:0] w_half_p1;

  assign w_last    = prescale - PRESCALE_W'(1);
  assign w_half    = prescale >> 1;
  assign w_half_m1 = w_half - PRESCALE_W'(1);
  assign w_half_p1 = w_half + PRESCALE_W'(1);

  assign vote        = maj3(r_s0, r_s1, rx_in);
  assign edge_cnt    = r_edge;
  assign bit_done    = (r_edge == w_last);
  assign sample_vld  = r_vld;
  assign sampled_bit = r_bit;

  // Edge counter wraps every bit period; idle holds it at 0 so the detection
  // cycle is edge 0. Samples are captured around mid-bit and voted.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_edge <= '0;
      r_s0   <= 1'b0;
      r_s1   <= 1'b0;
      r_vld  <= 1'b0;
      r_bit  <= 1'b0;
    end else begin
      r_vld <= 1'b0;
      if (!cnt_en) begin
        r_edge <= '0;
      end else begin
        r_edge <= (r_edge == w_last) ? '0 : r_edge + PRESCALE_W'(1);
        if (r_edge == w_half_m1) r_s0 <= rx_in;
        if (r_edge == w_half)    r_s1 <= rx_in;
        if (r_edge == w_half_p1) begin
          r_vld <= 1'b1;
          r_bit <= vote;
        end
      end
    end
  end

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: start / DATA_WIDTH data bits (LSB first) /
// optional parity / stop. Good frames load p_data and pulse data_valid;
// parity and stop failures pulse par_err / stp_err instead.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PRESCALE_W = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_in,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  par_en,
  input  logic                  par_typ,
  output logic [DATA_WIDTH-1:0] p_data,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err
);

  localparam int unsigned BitCntW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BitCntW-1:0] LastBit = BitCntW'(DATA_WIDTH - 1);

  rx_state_t             r_state;
  logic [BitCntW-1:0]    r_bit_cnt;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [PRESCALE_W-1:0] r_prescale;
  logic                  r_par_en;
  logic                  r_par_typ;
  logic                  r_par_flag;
  logic [DATA_WIDTH-1:0] r_p_data;
  logic                  r_data_valid;
  logic                  r_par_err;
  logic                  r_stp_err;

  logic                  w_detect;
  logic                  w_to_idle;
  logic                  w_cnt_en;
  logic [PRESCALE_W-1:0] w_prescale;
  logic [PRESCALE_W-1:0] w_edge_cnt;
  logic [PRESCALE_W-1:0] w_half_p1;
  logic                  w_vote_stb;
  logic                  w_bit_done;
  logic                  w_sample_vld;
  logic                  w_sampled_bit;
  logic                  w_vote;
  logic                  w_exp_par;

  assign w_detect  = (r_state == StIdle) && !rx_in;
  assign w_to_idle = w_sample_vld &&
                     (((r_state == StStart) && w_sampled_bit) || (r_state == StStop));
  assign w_cnt_en  = w_detect || ((r_state != StIdle) && !w_to_idle);
  // Live prescale on the detection cycle, captured copy for the rest of the frame
  assign w_prescale = w_detect ? prescale : r_prescale;
  assign w_half_p1  = (r_prescale >> 1) + PRESCALE_W'(1);
  // Stop results are registered one edge early so they show during edge P/2+2
  assign w_vote_stb = (w_edge_cnt == w_half_p1);
  assign w_exp_par  = (^r_shift) ^ (r_par_typ == PAR_ODD);

  assign p_data     = r_p_data;
  assign data_valid = r_data_valid;
  assign par_err    = r_par_err;
  assign stp_err    = r_stp_err;

  uart_rx_sampler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_sampler (
    .clk         (clk),
    .rst         (rst),
    .rx_in       (rx_in),
    .prescale    (w_prescale),
    .cnt_en      (w_cnt_en),
    .edge_cnt    (w_edge_cnt),
    .bit_done    (w_bit_done),
    .sample_vld  (w_sample_vld),
    .sampled_bit (w_sampled_bit),
    .vote        (w_vote)
  );

  // Frame FSM with bit counter, shift register, parity flag and result pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= StIdle;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_prescale   <= '0;
      r_par_en     <= 1'b0;
      r_par_typ    <= 1'b0;
      r_par_flag   <= 1'b0;
      r_p_data     <= '0;
      r_data_valid <= 1'b0;
      r_par_err    <= 1'b0;
      r_stp_err    <= 1'b0;
    end else begin
      r_data_valid <= 1'b0;
      r_par_err    <= 1'b0;
      r_stp_err    <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (!rx_in) begin
            r_state    <= StStart;
            r_prescale <= prescale;
            r_par_en   <= par_en;
            r_par_typ  <= par_typ;
            r_par_flag <= 1'b0;
            r_bit_cnt  <= '0;
          end
        end
        StStart: begin
          if (w_sample_vld && w_sampled_bit) begin
            r_state <= StIdle;  // line was high at mid-bit: glitch
          end else if (w_bit_done) begin
            r_state <= StData;
          end
        end
        StData: begin
          if (w_sample_vld) r_shift <= {w_sampled_bit, r_shift[DATA_WIDTH-1:1]};
          if (w_bit_done) begin
            if (r_bit_cnt == LastBit) begin
              r_bit_cnt <= '0;
              r_state   <= r_par_en ? StParity : StStop;
            end else begin
              r_bit_cnt <= r_bit_cnt + BitCntW'(1);
            end
          end
        end
        StParity: begin
          if (w_sample_vld && (w_sampled_bit != w_exp_par)) r_par_flag <= 1'b1;
          if (w_bit_done) r_state <= StStop;
        end
        StStop: begin
          if (w_vote_stb) begin
            r_stp_err <= !w_vote;
            r_par_err <= r_par_flag;
            if (w_vote && !r_par_flag) begin
              r_p_data     <= r_shift;
              r_data_valid <= 1'b1;
            end
          end
          // Leave mid-stop-bit so a back-to-back start bit is seen on its first low cycle
          if (w_sample_vld) r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: a table of single frames plus hand-written
// sequences for start glitch, mid-frame reset and back-to-back frames.
module tb_uart_rx;

  localparam int PW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          rx_in;
  logic [PW-1:0] prescale;
  logic          par_en;
  logic          par_typ;
  logic [7:0]    p_data;
  logic          data_valid;
  logic          par_err;
  logic          stp_err;

  always #5 clk = ~clk;

  uart_rx #(
    .DATA_WIDTH (8),
    .PRESCALE_W (PW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_in      (rx_in),
    .prescale   (prescale),
    .par_en     (par_en),
    .par_typ    (par_typ),
    .p_data     (p_data),
    .data_valid (data_valid),
    .par_err    (par_err),
    .stp_err    (stp_err)
  );

  typedef struct {
    int         p;
    bit         pen;
    bit         ptyp;
    logic [7:0] data;
    bit         pbit;
    bit         stopb;
    bit         scr;
    int         exp_cyc;
    bit         exp_dv;
    bit         exp_pe;
    bit         exp_se;
    logic [7:0] exp_pd;
  } vec_t;

  vec_t vecs[9];

  int n_pass = 0;
  int n_tot  = 0;
  int cyc    = 0;
  int t0     = 0;
  int pulse_n  = 0;
  int last_cyc = 0;
  int prev_cyc = 0;
  bit last_dv, last_pe, last_se;
  logic [7:0] last_pd;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every result pulse, sampled mid-cycle
  always @(negedge clk) begin
    if (!rst && (data_valid || par_err || stp_err)) begin
      pulse_n  <= pulse_n + 1;
      prev_cyc <= last_cyc;
      last_cyc <= cyc;
      last_dv  <= data_valid;
      last_pe  <= par_err;
      last_se  <= stp_err;
      last_pd  <= p_data;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one full frame starting now; leaves the line high at cycle N*P
  task automatic send_frame(input int p, input bit pen, input bit ptyp, input logic [7:0] d,
                            input bit pbit, input bit stopb, input bit scr);
    bit bits[11];
    int nb;
    prescale = PW'(p);
    par_en   = pen;
    par_typ  = ptyp;
    bits[0]  = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = d[i];
    nb = 9;
    if (pen) begin
      bits[nb] = pbit;
      nb = nb + 1;
    end
    bits[nb] = stopb;
    nb = nb + 1;
    t0 = cyc;
    for (int i = 0; i < nb; i++) begin
      rx_in = bits[i];
      tick(p);
      if (i == 0 && scr) begin
        prescale = (p == 32) ? PW'(8) : PW'(32);
        par_en   = ~pen;
        par_typ  = ~ptyp;
      end
    end
    rx_in = 1'b1;
  endtask

  task automatic check_single(input string tag, input int exp_cyc, input bit dv, input bit pe,
                              input bit se, input logic [7:0] pd);
    check($sformatf("%s pulses", tag), pulse_n, 1);
    check($sformatf("%s cycle", tag), last_cyc - t0, exp_cyc);
    check($sformatf("%s data_valid", tag), int'(last_dv), int'(dv));
    check($sformatf("%s par_err", tag), int'(last_pe), int'(pe));
    check($sformatf("%s stp_err", tag), int'(last_se), int'(se));
    check($sformatf("%s p_data@pulse", tag), int'(last_pd), int'(pd));
    check($sformatf("%s p_data held", tag), int'(p_data), int'(pd));
  endtask

  initial begin
    logic [7:0] c3;
    c3 = 8'hC3;
    rst = 1'b1;
    rx_in = 1'b1;
    prescale = PW'(8);
    par_en = 1'b0;
    par_typ = 1'b0;

    //          p  pen ptyp data  pbit stop scr cyc  dv pe se  pd
    vecs[0] = '{8,  0, 0, 8'hA5, 0, 1, 0, 78,  1, 0, 0, 8'hA5};
    vecs[1] = '{16, 1, 0, 8'h3C, 0, 1, 1, 170, 1, 0, 0, 8'h3C};
    vecs[2] = '{16, 1, 0, 8'h3C, 1, 1, 0, 170, 0, 1, 0, 8'h3C};
    vecs[3] = '{8,  1, 1, 8'h01, 0, 0, 0, 86,  0, 0, 1, 8'h3C};
    vecs[4] = '{8,  1, 1, 8'h7E, 1, 1, 0, 86,  1, 0, 0, 8'h7E};
    vecs[5] = '{32, 0, 0, 8'h96, 0, 1, 0, 306, 1, 0, 0, 8'h96};
    vecs[6] = '{8,  1, 0, 8'h80, 0, 1, 0, 86,  0, 1, 0, 8'h96};
    vecs[7] = '{8,  1, 0, 8'h0F, 1, 0, 0, 86,  0, 1, 1, 8'h96};
    vecs[8] = '{16, 0, 0, 8'h00, 0, 1, 0, 154, 1, 0, 0, 8'h00};

    tick(3);
    rst = 1'b0;
    @(negedge clk);
    check("reset p_data", int'(p_data), 0);
    check("reset data_valid", int'(data_valid), 0);
    check("reset par_err", int'(par_err), 0);
    check("reset stp_err", int'(stp_err), 0);
    tick(4);

    for (int v = 0; v < 9; v++) begin
      pulse_n = 0;
      send_frame(vecs[v].p, vecs[v].pen, vecs[v].ptyp, vecs[v].data, vecs[v].pbit,
                 vecs[v].stopb, vecs[v].scr);
      check_single($sformatf("vec%0d", v), vecs[v].exp_cyc, vecs[v].exp_dv, vecs[v].exp_pe,
                   vecs[v].exp_se, vecs[v].exp_pd);
      tick(40);
    end

    // Start glitch of 3 low cycles, then a frame at the earliest re-detection cycle P/2+3
    pulse_n = 0;
    prescale = PW'(8);
    par_en = 1'b0;
    rx_in = 1'b0;
    tick(3);
    rx_in = 1'b1;
    tick(4);
    send_frame(8, 0, 0, 8'h55, 0, 1, 0);
    check_single("glitch+55", 78, 1, 0, 0, 8'h55);
    tick(40);

    // Reset during data bit 4
    pulse_n = 0;
    rx_in = 1'b0;
    tick(8);
    for (int i = 0; i < 4; i++) begin
      rx_in = c3[i];
      tick(8);
    end
    rx_in = c3[4];
    tick(2);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    rx_in = 1'b1;
    @(negedge clk);
    check("midrst p_data", int'(p_data), 0);
    check("midrst data_valid", int'(data_valid), 0);
    check("midrst par_err", int'(par_err), 0);
    check("midrst stp_err", int'(stp_err), 0);
    tick(100);
    check("midrst no pulses", pulse_n, 0);
    send_frame(8, 0, 0, 8'hC3, 0, 1, 0);
    check_single("after-rst C3", 78, 1, 0, 0, 8'hC3);
    tick(40);

    // Back-to-back frames with zero idle between them
    pulse_n = 0;
    send_frame(32, 0, 0, 8'hFF, 0, 1, 0);
    check("b2b first p_data", int'(last_pd), 8'hFF);
    send_frame(32, 0, 0, 8'h00, 0, 1, 0);
    check("b2b pulses", pulse_n, 2);
    check("b2b spacing", last_cyc - prev_cyc, 320);
    check("b2b second cycle", last_cyc - t0, 306);
    check("b2b second data_valid", int'(last_dv), 1);
    check("b2b second p_data", int'(last_pd), 8'h00);
    tick(10);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
